// File: rtl/ram_line_ctrl_if.sv
// ram_line_ctrl_if: request/response bundle between the cache controller and the line sequencer
interface ram_line_ctrl_if #(
  parameter int LINE_WORDS = 4
);
  logic req_valid;
  logic req_ready;
  logic req_wb;
  logic req_fill;
  logic [19:0] wb_addr;
  logic [19:0] fill_addr;
  logic [32*LINE_WORDS-1:0] wb_data;
  logic [32*LINE_WORDS-1:0] fill_data;
  logic done;
  modport master (
    output req_valid, req_wb, req_fill, wb_addr, fill_addr, wb_data,
    input req_ready, fill_data, done
  );
  modport slave (
    input req_valid, req_wb, req_fill, wb_addr, fill_addr, wb_data,
    output req_ready, fill_data, done
  );
endinterface

// File: rtl/ram_line_ctrl.sv
// ram_line_ctrl: walks a cache line word by word over an async byte-enable RAM for write-back and/or fill
// RAM_LINE_CTRL_PERF_EN adds saturating write-back/fill transaction counters.
module ram_line_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  ram_line_ctrl_if.slave bus,
  output logic ram_we,
  output logic [19:0] ram_addr,
  output logic [31:0] ram_din,
  output logic [3:0] ram_be,
  input  logic [31:0] ram_dout
`ifdef RAM_LINE_CTRL_PERF_EN
  ,
  output logic [15:0] perf_wb_cnt,
  output logic [15:0] perf_fill_cnt
`endif
);
  localparam int W_IDX = $clog2(LINE_WORDS);
  localparam int HW = ACCESS_CYCLES > 1 ? $clog2(ACCESS_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;
  state_t state, state_n;
  logic [W_IDX-1:0] wc, wc_n;
  logic [HW-1:0] hc, hc_n;
  logic [19:0] wb_base, wb_base_n, fill_base, fill_base_n;
  logic [32*LINE_WORDS-1:0] wb_line, wb_line_n, fill_line;
  logic do_wb, do_wb_n, do_fill, do_fill_n;
  logic accept, last_hold, last_word, capture;
  logic ram_we_n, done_n, done_q;
  logic [19:0] ram_addr_n;
  logic [31:0] ram_din_n;
  logic [3:0] ram_be_n;
  assign bus.req_ready = state == IDLE && !rst;
  assign bus.fill_data = fill_line;
  assign bus.done = done_q;
  assign accept = bus.req_valid && bus.req_ready;
  assign last_hold = hc == HW'(ACCESS_CYCLES - 1);
  assign last_word = wc == W_IDX'(LINE_WORDS - 1);
  assign capture = state == FILL && last_hold;
  // Request fields are taken straight from the bus on the accept edge so word 0 is driven in the first busy cycle.
  assign wb_base_n = accept ? bus.wb_addr & ~20'(LINE_WORDS - 1) : wb_base;
  assign fill_base_n = accept ? bus.fill_addr & ~20'(LINE_WORDS - 1) : fill_base;
  assign wb_line_n = accept ? bus.wb_data : wb_line;
  assign do_wb_n = accept ? bus.req_wb : do_wb;
  assign do_fill_n = accept ? bus.req_fill : do_fill;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wc <= '0;
      hc <= '0;
      wb_base <= '0;
      fill_base <= '0;
      wb_line <= '0;
      fill_line <= '0;
      do_wb <= 1'b0;
      do_fill <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_din <= '0;
      ram_be <= '0;
      done_q <= 1'b0;
    end else begin
      state <= state_n;
      wc <= wc_n;
      hc <= hc_n;
      wb_base <= wb_base_n;
      fill_base <= fill_base_n;
      wb_line <= wb_line_n;
      do_wb <= do_wb_n;
      do_fill <= do_fill_n;
      ram_we <= ram_we_n;
      ram_addr <= ram_addr_n;
      ram_din <= ram_din_n;
      ram_be <= ram_be_n;
      done_q <= done_n;
      if (capture) fill_line[{wc, 5'd0} +: 32] <= ram_dout;
    end
  end
  always_comb begin
    state_n = state;
    wc_n = wc;
    hc_n = hc;
    case (state)
      IDLE: begin
        if (accept) state_n = bus.req_wb ? WB : bus.req_fill ? FILL : DONE;
        wc_n = '0;
        hc_n = '0;
      end
      WB, FILL: begin
        hc_n = last_hold ? '0 : hc + 1'b1;
        wc_n = last_hold ? wc + 1'b1 : wc;
        if (last_hold && last_word) state_n = state == WB && do_fill ? FILL : DONE;
      end
      default: state_n = IDLE;
    endcase
  end
  // Outputs are registered from the next-state view; we drops on each word's final hold cycle.
  always_comb begin
    ram_we_n = state_n == WB && hc_n != HW'(ACCESS_CYCLES - 1);
    ram_addr_n = state_n == WB ? wb_base_n | 20'(wc_n) :
                 state_n == FILL ? fill_base_n | 20'(wc_n) : ram_addr;
    ram_din_n = state_n == WB ? wb_line_n[{wc_n, 5'd0} +: 32] : ram_din;
    ram_be_n = state_n == WB ? 4'hF : 4'h0;
    done_n = state_n == DONE;
  end
`ifdef RAM_LINE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_wb_cnt <= '0;
      perf_fill_cnt <= '0;
    end else if (state == DONE) begin
      perf_wb_cnt <= perf_wb_cnt + 16'(do_wb && perf_wb_cnt != 16'hFFFF);
      perf_fill_cnt <= perf_fill_cnt + 16'(do_fill && perf_fill_cnt != 16'hFFFF);
    end
  end
`endif
  a_wb_hold: assert property (@(posedge clk) disable iff (rst) accept && bus.req_wb |-> ACCESS_CYCLES >= 2);
endmodule
